plazer_master_0_b2p: RTL and testbench
======================================

# plazer_master_0_b2p

Byte-stream-to-packet decoder sitting directly downstream of the master's Avalon-ST timing adapter. It consumes the adapter's 8-bit byte stream, strips the in-band framing/escape characters, and emits an Avalon-ST packet stream with start/end-of-packet markers and a channel number toward the master's packet consumer. Output is registered: one data byte in, one data byte out one cycle later; control bytes produce no output beat.

## Interface
- CHANNEL_WIDTH, 8, width of out_channel; the received channel byte is truncated to the low CHANNEL_WIDTH bits.

- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  byte valid from timing adapter.
- in_data  in  8  stream byte.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- out_valid  out  1  decoded data beat valid.
- out_data  out  8  decoded (unescaped) data byte.
- out_startofpacket  out  1  first beat of packet.
- out_endofpacket  out  1  last beat of packet.
- out_channel  out  CHANNEL_WIDTH  channel of this beat.
- out_ready  in  1  downstream ready.

## Operation
- Special bytes: SOP 0x7A, EOP 0x7B, CHAN 0x7C, ESC 0x7D.
- Internal state: esc_pending, chan_pending, sop_pending, eop_pending, chan_reg[CHANNEL_WIDTH-1:0], plus output register (out_valid, out_data, out_startofpacket, out_endofpacket, out_channel).
- Accepted byte b, processed in priority order:
  - esc_pending set: d = b ^ 0x20; clear esc_pending; d is then treated as a literal (chan load or data beat), never as control.
  - b = ESC: set esc_pending; no beat.
  - b = SOP: set sop_pending, clear chan_pending; no beat.
  - b = EOP: set eop_pending, clear chan_pending; no beat.
  - b = CHAN: set chan_pending; no beat.
  - otherwise literal d = b.
- Literal d with chan_pending set: chan_reg <= d[CHANNEL_WIDTH-1:0]; clear chan_pending; no beat.
- Literal d otherwise: load output register: out_data <= d, out_startofpacket <= sop_pending, out_endofpacket <= eop_pending, out_channel <= chan_reg (as updated before this byte); clear sop_pending and eop_pending.
- Repeated SOP or EOP before a data byte: flag stays set (idempotent). ESC while chan_pending: chan_pending kept; escaped byte loads channel.
- chan_reg persists across packets until next CHAN load.
- No framing-error detection: EOP without prior SOP, or data outside a packet, is passed through with flags as pending.

## Timing
- in_ready = out_ready || !out_valid (combinational; no bubble in steady state).
- Data byte accepted in cycle N -> out_valid high from cycle N+1; control bytes consume one cycle, no output.
- out_valid clears on out_valid && out_ready with no new load in same cycle; simultaneous drain and load keeps out_valid high with new contents.
- Output register fields hold while out_valid && !out_ready.
- Reset (asserted any time, including mid-packet or between ESC and its operand): out_valid 0, out_data 0, out_startofpacket 0, out_endofpacket 0, out_channel 0, chan_reg 0, all pending flags 0. First byte after reset release is decoded from idle state.
- Throughput: one byte per cycle when out_ready held high.

## Structure
- Shared package plazer_st_pkg: SOP_CHAR, EOP_CHAR, CHAN_CHAR, ESC_CHAR, ESC_XOR (0x20) constants; reused by the matching packet-to-byte encoder on the return path.
- Single module; no sub-module — the output register and flag logic are too small to split.

## Test plan
- Bytes 7A 11 22 7B 33, out_ready=1 -> beats 11(sop=1,eop=0), 22(0,0), 33(sop=0,eop=1), each one cycle after acceptance, channel 0.
- Bytes 7C 05 7A 7B 44 -> single beat 44, sop=1, eop=1, out_channel=5.
- Bytes 7A 7D 5A 7D 5D 7B 7D 5C -> beats 7A(sop), 7D, 7C(eop); escaped values never act as control.
- Bytes 7C 7D 5B 99 -> out_channel=0x7B on beat 99; no beat for 7C/7D/5B.
- Data stream with out_ready low 3 cycles after first beat -> in_ready low, out_data/flags held stable, no byte lost or duplicated on resume.
- Reset pulse after 7A 7D -> all outputs 0; following byte 5A emitted as plain 5A, sop=0.

Source files
------------

// File: rtl/plazer_st_pkg.sv
// Framing characters shared by the byte-to-packet decoder and the matching
// packet-to-byte encoder on the return path.
package plazer_st_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef logic [BYTE_W-1:0] st_byte_t;

  localparam st_byte_t SOP_CHAR  = 8'h7A;
  localparam st_byte_t EOP_CHAR  = 8'h7B;
  localparam st_byte_t CHAN_CHAR = 8'h7C;
  localparam st_byte_t ESC_CHAR  = 8'h7D;
  localparam st_byte_t ESC_XOR   = 8'h20;

  typedef enum logic [2:0] {
    K_LIT,
    K_ESC,
    K_SOP,
    K_EOP,
    K_CHAN
  } byte_kind_t;

  // Classify an unescaped stream byte.
  function automatic byte_kind_t classify(input st_byte_t b);
    byte_kind_t k;
    unique case (b)
      ESC_CHAR:  k = K_ESC;
      SOP_CHAR:  k = K_SOP;
      EOP_CHAR:  k = K_EOP;
      CHAN_CHAR: k = K_CHAN;
      default:   k = K_LIT;
    endcase
    return k;
  endfunction

  // True when a byte must be escaped on the wire.
  function automatic logic is_special(input st_byte_t b);
    return classify(b) != K_LIT;
  endfunction

endpackage

// File: rtl/plazer_master_0_b2p.sv
// Byte-stream to Avalon-ST packet decoder: strips SOP/EOP/CHAN/ESC framing
// and emits registered data beats with packet markers and channel.
module plazer_master_0_b2p
  import plazer_st_pkg::*;
#(
  parameter int unsigned CHANNEL_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [BYTE_W-1:0]        in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [BYTE_W-1:0]        out_data,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic [CHANNEL_WIDTH-1:0] out_channel,
  input  logic                     out_ready
);

  logic                     esc_pending, esc_pending_n;
  logic                     chan_pending, chan_pending_n;
  logic                     sop_pending, sop_pending_n;
  logic                     eop_pending, eop_pending_n;
  logic [CHANNEL_WIDTH-1:0] chan_reg, chan_reg_n;

  logic                     out_valid_n;
  logic [BYTE_W-1:0]        out_data_n;
  logic                     out_sop_n;
  logic                     out_eop_n;
  logic [CHANNEL_WIDTH-1:0] out_channel_n;

  logic                     accept;
  logic                     lit_valid;
  st_byte_t                 lit;

  // Output register is free when empty or draining this cycle.
  assign in_ready = out_ready || !out_valid;
  assign accept   = in_valid && in_ready;

  // Decode one accepted byte; escaped operands are always literals.
  always_comb begin : decode
    esc_pending_n  = esc_pending;
    chan_pending_n = chan_pending;
    sop_pending_n  = sop_pending;
    eop_pending_n  = eop_pending;
    chan_reg_n     = chan_reg;
    out_valid_n    = out_valid;
    out_data_n     = out_data;
    out_sop_n      = out_startofpacket;
    out_eop_n      = out_endofpacket;
    out_channel_n  = out_channel;
    lit            = in_data;
    lit_valid      = 1'b0;

    if (out_valid && out_ready) begin
      out_valid_n = 1'b0;
    end

    if (accept) begin
      if (esc_pending) begin
        esc_pending_n = 1'b0;
        lit           = in_data ^ ESC_XOR;
        lit_valid     = 1'b1;
      end else begin
        unique case (classify(in_data))
          K_ESC:  esc_pending_n = 1'b1;
          K_SOP: begin
            sop_pending_n  = 1'b1;
            chan_pending_n = 1'b0;
          end
          K_EOP: begin
            eop_pending_n  = 1'b1;
            chan_pending_n = 1'b0;
          end
          K_CHAN: chan_pending_n = 1'b1;
          default: lit_valid = 1'b1;
        endcase
      end

      if (lit_valid) begin
        if (chan_pending) begin
          chan_reg_n     = CHANNEL_WIDTH'(lit);
          chan_pending_n = 1'b0;
        end else begin
          out_valid_n   = 1'b1;
          out_data_n    = lit;
          out_sop_n     = sop_pending;
          out_eop_n     = eop_pending;
          out_channel_n = chan_reg;
          sop_pending_n = 1'b0;
          eop_pending_n = 1'b0;
        end
      end
    end
  end

  // Decoder flags, channel latch and output beat register.
  always_ff @(posedge clk or posedge reset) begin : regs
    if (reset) begin
      esc_pending       <= 1'b0;
      chan_pending      <= 1'b0;
      sop_pending       <= 1'b0;
      eop_pending       <= 1'b0;
      chan_reg          <= '0;
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
      out_channel       <= '0;
    end else begin
      esc_pending       <= esc_pending_n;
      chan_pending      <= chan_pending_n;
      sop_pending       <= sop_pending_n;
      eop_pending       <= eop_pending_n;
      chan_reg          <= chan_reg_n;
      out_valid         <= out_valid_n;
      out_data          <= out_data_n;
      out_startofpacket <= out_sop_n;
      out_endofpacket   <= out_eop_n;
      out_channel       <= out_channel_n;
    end
  end

endmodule

// File: tb/tb_plazer_master_0_b2p.sv
// Bench for the byte-to-packet decoder: directed framing cases plus random
// traffic scored against a queue-based model of the decoding rules.
module tb_plazer_master_0_b2p;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_startofpacket;
  logic       out_endofpacket;
  logic [7:0] out_channel;
  logic       out_ready;

  always #5 clk = ~clk;

  plazer_master_0_b2p #(.CHANNEL_WIDTH(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_ready          (in_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_channel       (out_channel),
    .out_ready         (out_ready)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       s;
    logic       e;
    logic [7:0] c;
  } beat_t;

  typedef logic [7:0] bytes_t[$];
  typedef beat_t      beats_t[$];

  beat_t exp_q[$];
  beat_t log_q[$];
  int    n_pass = 0;
  int    n_chk  = 0;
  bit    rnd_on = 1'b0;

  bit         m_esc, m_chan, m_sop, m_eop;
  logic [7:0] m_ch;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_esc = 0; m_chan = 0; m_sop = 0; m_eop = 0; m_ch = 8'h00;
    exp_q.delete();
  endfunction

  // Decoding rules applied to one accepted byte.
  function automatic void model_byte(input logic [7:0] b);
    logic [7:0] d;
    bit literal;
    literal = 0;
    d = b;
    if (m_esc) begin
      m_esc = 0; d = b ^ 8'h20; literal = 1;
    end else if (b == 8'h7D) m_esc = 1;
    else if (b == 8'h7A) begin m_sop = 1; m_chan = 0; end
    else if (b == 8'h7B) begin m_eop = 1; m_chan = 0; end
    else if (b == 8'h7C) m_chan = 1;
    else literal = 1;
    if (literal) begin
      if (m_chan) begin
        m_ch = d; m_chan = 0;
      end else begin
        exp_q.push_back('{d: d, s: m_sop, e: m_eop, c: m_ch});
        m_sop = 0; m_eop = 0;
      end
    end
  endfunction

  // Per-cycle scoreboard; a beat presented at this edge is consumed if out_ready.
  always @(negedge clk) begin
    beat_t act;
    if (reset) begin
      model_reset();
    end else begin
      act = '{d: out_data, s: out_startofpacket, e: out_endofpacket, c: out_channel};
      check("in_ready", 32'(in_ready), 32'(out_ready || !out_valid));
      if (out_valid) begin
        check("outstanding_beats", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) begin
          check("beat", 32'(act), 32'(exp_q[0]));
          if (out_ready) begin
            log_q.push_back(act);
            void'(exp_q.pop_front());
          end
        end
      end else begin
        check("idle_no_pending_beat", 32'(exp_q.size()), 32'd0);
      end
      if (in_valid && in_ready) model_byte(in_data);
    end
  end

  task automatic send(input logic [7:0] b);
    bit done;
    done = 0;
    in_valid = 1'b1;
    in_data  = b;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_seq(input bytes_t s);
    foreach (s[i]) send(s[i]);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic expect_log(input string name, input beats_t e);
    check({name, "_count"}, 32'(log_q.size()), 32'(e.size()));
    foreach (e[i])
      if (i < log_q.size()) check(name, 32'(log_q[i]), 32'(e[i]));
    log_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_sop", 32'(out_startofpacket), 32'd0);
    check("rst_eop", 32'(out_endofpacket), 32'd0);
    check("rst_channel", 32'(out_channel), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    log_q.delete();
  endtask

  function automatic logic [7:0] rnd_byte();
    logic [7:0] sp[4];
    sp[0] = 8'h7A; sp[1] = 8'h7B; sp[2] = 8'h7C; sp[3] = 8'h7D;
    if ($urandom_range(0, 9) < 4) return sp[$urandom_range(0, 3)];
    return 8'($urandom());
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    do_reset();
    send_seq('{8'h7A, 8'h11, 8'h22, 8'h7B, 8'h33});
    drain();
    expect_log("basic_packet", '{'{8'h11, 1'b1, 1'b0, 8'h00},
                                 '{8'h22, 1'b0, 1'b0, 8'h00},
                                 '{8'h33, 1'b0, 1'b1, 8'h00}});

    do_reset();
    send_seq('{8'h7C, 8'h05, 8'h7A, 8'h7B, 8'h44, 8'h7A, 8'h7A, 8'h55});
    drain();
    expect_log("channel_persist", '{'{8'h44, 1'b1, 1'b1, 8'h05},
                                    '{8'h55, 1'b1, 1'b0, 8'h05}});

    do_reset();
    send_seq('{8'h7A, 8'h7D, 8'h5A, 8'h7D, 8'h5D, 8'h7B, 8'h7D, 8'h5C});
    drain();
    expect_log("escaped_data", '{'{8'h7A, 1'b1, 1'b0, 8'h00},
                                 '{8'h7D, 1'b0, 1'b0, 8'h00},
                                 '{8'h7C, 1'b0, 1'b1, 8'h00}});

    do_reset();
    send_seq('{8'h7C, 8'h7D, 8'h5B, 8'h99});
    drain();
    expect_log("escaped_channel", '{'{8'h99, 1'b0, 1'b0, 8'h7B}});

    do_reset();
    fork
      send_seq('{8'h11, 8'h22, 8'h33, 8'h44});
      begin
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    expect_log("stall", '{'{8'h11, 1'b0, 1'b0, 8'h00},
                          '{8'h22, 1'b0, 1'b0, 8'h00},
                          '{8'h33, 1'b0, 1'b0, 8'h00},
                          '{8'h44, 1'b0, 1'b0, 8'h00}});

    do_reset();
    send_seq('{8'h7A, 8'h7D});
    do_reset();
    send(8'h5A);
    drain();
    expect_log("reset_mid_escape", '{'{8'h5A, 1'b0, 1'b0, 8'h00}});

    do_reset();
    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 1500; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(rnd_byte());
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    check("random_all_drained", 32'(exp_q.size()), 32'd0);
    log_q.delete();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
